// File: rtl/interrupt_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_sequencer_pkg
// Description : Shared source encoding, sequence cycle numbers, push-select
//               codes and default vector addresses for the interrupt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_sequencer_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RES  = 2'd1,
        SRC_NMI  = 2'd2,
        SRC_IRQ  = 2'd3
    } src_t;

    localparam logic [2:0] CYC_IDLE     = 3'd0;
    localparam logic [2:0] CYC_OPCODE   = 3'd1;
    localparam logic [2:0] CYC_DUMMY    = 3'd2;
    localparam logic [2:0] CYC_PUSH_PCH = 3'd3;
    localparam logic [2:0] CYC_PUSH_PCL = 3'd4;
    localparam logic [2:0] CYC_PUSH_P   = 3'd5;
    localparam logic [2:0] CYC_VECLO    = 3'd6;
    localparam logic [2:0] CYC_VECHI    = 3'd7;

    localparam logic [1:0] PUSH_SEL_PCH = 2'd0;
    localparam logic [1:0] PUSH_SEL_PCL = 2'd1;
    localparam logic [1:0] PUSH_SEL_P   = 2'd2;

    localparam logic [15:0] NMI_VEC_DEFAULT = 16'hFFFA;
    localparam logic [15:0] RES_VEC_DEFAULT = 16'hFFFC;
    localparam logic [15:0] IRQ_VEC_DEFAULT = 16'hFFFE;

endpackage
`default_nettype wire

// File: rtl/int_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : int_priority_select
// Description : Combinational arbitration of res > nmi > unmasked irq.
// Revision    : 1.0 - initial release
// ============================================================================
module int_priority_select
    import interrupt_sequencer_pkg::*;
(
    input  logic res,
    input  logic nmi,
    input  logic irq,
    input  logic iFlag,
    output src_t src
);

    always_comb begin
        src = SRC_NONE;
        if (res)
            src = SRC_RES;
        else if (nmi)
            src = SRC_NMI;
        else if (irq && !iFlag)
            src = SRC_IRQ;
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_sequencer
// Description : Runs the 7-cycle 6502 interrupt/reset sequence at instruction
//               boundaries and issues the per-source acknowledge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] NMI_VEC = NMI_VEC_DEFAULT,
    parameter logic [15:0] RES_VEC = RES_VEC_DEFAULT,
    parameter logic [15:0] IRQ_VEC = IRQ_VEC_DEFAULT
)
(
    input  logic        phi1,
    input  logic        rstAll,
    input  logic        nmi,
    input  logic        irq,
    input  logic        res,
    input  logic        iFlag,
    input  logic        instrBoundary,
    input  logic        RDYout,
    output logic        intActive,
    output logic [2:0]  seqCycle,
    output logic        pushEn,
    output logic [1:0]  pushSel,
    output logic        vecRead,
    output logic [15:0] vectorAddr,
    output logic        setI,
    output logic        nmiHandled,
    output logic        irqHandled,
    output logic        resHandled
);

    src_t       req_src;
    src_t       src_q,         src_d;
    logic [2:0] seq_cycle_q,   seq_cycle_d;
    logic       nmi_handled_q, nmi_handled_d;
    logic       irq_handled_q, irq_handled_d;
    logic       res_handled_q, res_handled_d;
    logic       is_push_cycle;
    logic       is_write;
    logic       stall;
    logic [15:0] vector_base;

    int_priority_select u_priority (
        .res   (res),
        .nmi   (nmi),
        .irq   (irq),
        .iFlag (iFlag),
        .src   (req_src)
    );

    // A reset sequence turns the three push slots into reads, so they can stall.
    always_comb begin
        is_push_cycle = (seq_cycle_q >= CYC_PUSH_PCH) && (seq_cycle_q <= CYC_PUSH_P);
        is_write      = is_push_cycle && (src_q != SRC_RES);
        stall         = !RDYout && (seq_cycle_q != CYC_IDLE) && !is_write;
    end

    always_comb begin
        seq_cycle_d   = seq_cycle_q;
        src_d         = src_q;
        nmi_handled_d = 1'b0;
        irq_handled_d = 1'b0;
        res_handled_d = 1'b0;

        if (seq_cycle_q == CYC_IDLE) begin
            if (instrBoundary && (req_src != SRC_NONE)) begin
                seq_cycle_d = CYC_OPCODE;
                src_d       = req_src;
            end
        end else if (res && (src_q != SRC_RES)) begin
            seq_cycle_d = CYC_OPCODE;
            src_d       = SRC_RES;
        end else begin
            // NMI may take over an IRQ sequence only before its vector is fetched.
            if ((src_q == SRC_IRQ) && nmi && (seq_cycle_q <= CYC_PUSH_P))
                src_d = SRC_NMI;

            if (!stall) begin
                if (seq_cycle_q == CYC_VECHI) begin
                    nmi_handled_d = (src_q == SRC_NMI);
                    irq_handled_d = (src_q == SRC_IRQ);
                    res_handled_d = (src_q == SRC_RES);
                    seq_cycle_d   = CYC_IDLE;
                    src_d         = SRC_NONE;
                    if (instrBoundary && (req_src != SRC_NONE)) begin
                        seq_cycle_d = CYC_OPCODE;
                        src_d       = req_src;
                    end
                end else begin
                    seq_cycle_d = seq_cycle_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge phi1 or posedge rstAll) begin
        if (rstAll) begin
            seq_cycle_q   <= CYC_IDLE;
            src_q         <= SRC_NONE;
            nmi_handled_q <= 1'b0;
            irq_handled_q <= 1'b0;
            res_handled_q <= 1'b0;
        end else begin
            seq_cycle_q   <= seq_cycle_d;
            src_q         <= src_d;
            nmi_handled_q <= nmi_handled_d;
            irq_handled_q <= irq_handled_d;
            res_handled_q <= res_handled_d;
        end
    end

    always_comb begin
        case (src_q)
            SRC_RES: vector_base = RES_VEC;
            SRC_NMI: vector_base = NMI_VEC;
            SRC_IRQ: vector_base = IRQ_VEC;
            default: vector_base = 16'h0000;
        endcase
    end

    always_comb begin
        pushSel = PUSH_SEL_PCH;
        if (is_write) begin
            case (seq_cycle_q)
                CYC_PUSH_PCL: pushSel = PUSH_SEL_PCL;
                CYC_PUSH_P:   pushSel = PUSH_SEL_P;
                default:      pushSel = PUSH_SEL_PCH;
            endcase
        end
    end

    always_comb begin
        vectorAddr = 16'h0000;
        if (seq_cycle_q == CYC_VECLO)
            vectorAddr = vector_base;
        else if (seq_cycle_q == CYC_VECHI)
            vectorAddr = vector_base + 16'd1;
    end

    assign seqCycle   = seq_cycle_q;
    assign intActive  = (seq_cycle_q != CYC_IDLE);
    assign pushEn     = is_write;
    assign vecRead    = (seq_cycle_q == CYC_VECLO) || (seq_cycle_q == CYC_VECHI);
    assign setI       = (seq_cycle_q == CYC_VECLO);
    assign nmiHandled = nmi_handled_q;
    assign irqHandled = irq_handled_q;
    assign resHandled = res_handled_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_sequencer
// Description : Scoreboard bench for interrupt_sequencer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_sequencer;

    typedef struct packed {
        logic [2:0]  seq;
        logic        act;
        logic        pe;
        logic [1:0]  ps;
        logic        vr;
        logic [15:0] va;
        logic        si;
        logic        nh;
        logic        ih;
        logic        rh;
    } exp_t;

    localparam logic [6:0] RST = 7'd64;
    localparam logic [6:0] RES = 7'd32;
    localparam logic [6:0] NMI = 7'd16;
    localparam logic [6:0] IRQ = 7'd8;
    localparam logic [6:0] IFL = 7'd4;
    localparam logic [6:0] IB  = 7'd2;
    localparam logic [6:0] RDY = 7'd1;

    localparam logic [15:0] V_NMI = 16'hFFFA;
    localparam logic [15:0] V_RES = 16'hFFFC;
    localparam logic [15:0] V_IRQ = 16'hFFFE;

    logic        phi1 = 1'b0;
    logic        rstAll = 1'b1;
    logic        nmi = 1'b0, irq = 1'b0, res = 1'b0, iFlag = 1'b0;
    logic        instrBoundary = 1'b0, RDYout = 1'b1;
    logic        intActive, pushEn, vecRead, setI;
    logic        nmiHandled, irqHandled, resHandled;
    logic [2:0]  seqCycle;
    logic [1:0]  pushSel;
    logic [15:0] vectorAddr;

    int checks = 0;
    int errors = 0;
    exp_t  exp_q[$];
    string name_q[$];
    exp_t  actual;

    interrupt_sequencer dut (
        .phi1          (phi1),
        .rstAll        (rstAll),
        .nmi           (nmi),
        .irq           (irq),
        .res           (res),
        .iFlag         (iFlag),
        .instrBoundary (instrBoundary),
        .RDYout        (RDYout),
        .intActive     (intActive),
        .seqCycle      (seqCycle),
        .pushEn        (pushEn),
        .pushSel       (pushSel),
        .vecRead       (vecRead),
        .vectorAddr    (vectorAddr),
        .setI          (setI),
        .nmiHandled    (nmiHandled),
        .irqHandled    (irqHandled),
        .resHandled    (resHandled)
    );

    always #5 phi1 = ~phi1;

    assign actual = '{seq: seqCycle, act: intActive, pe: pushEn, ps: pushSel,
                      vr: vecRead, va: vectorAddr, si: setI,
                      nh: nmiHandled, ih: irqHandled, rh: resHandled};

    // Expected outputs while in sequence cycle n of a source with vector vbase.
    function automatic exp_t C(input int n, input logic [15:0] vbase, input bit is_res);
        exp_t e = '0;
        e.seq = 3'(n);
        e.act = 1'b1;
        case (n)
            3: e.pe = !is_res;
            4: begin e.pe = !is_res; e.ps = is_res ? 2'd0 : 2'd1; end
            5: begin e.pe = !is_res; e.ps = is_res ? 2'd0 : 2'd2; end
            6: begin e.vr = 1'b1; e.va = vbase; e.si = 1'b1; end
            7: begin e.vr = 1'b1; e.va = vbase + 16'd1; end
            default: ;
        endcase
        return e;
    endfunction

    // Idle outputs with acknowledge bits {nmi, irq, res}.
    function automatic exp_t D(input logic [2:0] acks);
        exp_t e = '0;
        {e.nh, e.ih, e.rh} = acks;
        return e;
    endfunction

    task automatic compare(input exp_t e, input string nm);
        checks++;
        if (actual !== e) begin
            errors++;
            $display("FAIL %s @%0t: got seq=%0d act=%b pe=%b ps=%0d vr=%b va=%h si=%b ack=%b%b%b, expected seq=%0d act=%b pe=%b ps=%0d vr=%b va=%h si=%b ack=%b%b%b",
                     nm, $time, actual.seq, actual.act, actual.pe, actual.ps, actual.vr, actual.va,
                     actual.si, actual.nh, actual.ih, actual.rh,
                     e.seq, e.act, e.pe, e.ps, e.vr, e.va, e.si, e.nh, e.ih, e.rh);
        end
    endtask

    // Inputs are applied just after a falling edge; the expectation is for the
    // state after the following rising edge.
    task automatic step(input logic [6:0] v, input exp_t e, input string nm);
        @(negedge phi1);
        #1;
        {rstAll, res, nmi, irq, iFlag, instrBoundary, RDYout} = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        forever begin
            @(negedge phi1);
            if (exp_q.size() > 0)
                compare(exp_q.pop_front(), name_q.pop_front());
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        step(RST, D(3'b000), "reset0");
        step(RST, D(3'b000), "reset1");
        step(RDY, D(3'b000), "reset_release");

        // Plain IRQ sequence
        step(IRQ | IB | RDY, C(1, V_IRQ, 0), "irq_c1");
        for (int n = 2; n <= 7; n++)
            step(IRQ | RDY, C(n, V_IRQ, 0), $sformatf("irq_c%0d", n));
        step(IRQ | RDY, D(3'b010), "irq_ack");
        step(RDY, D(3'b000), "irq_after");

        // Masked IRQ
        step(IRQ | IFL | IB | RDY, D(3'b000), "irq_masked0");
        step(IRQ | IFL | IB | RDY, D(3'b000), "irq_masked1");
        step(RDY, D(3'b000), "irq_masked2");

        // Reset sequence with a read stall in cycle 4
        step(RES | IB | RDY, C(1, V_RES, 1), "res_c1");
        step(RDY, C(2, V_RES, 1), "res_c2");
        step(RDY, C(3, V_RES, 1), "res_c3");
        step(RDY, C(4, V_RES, 1), "res_c4");
        step(7'd0, C(4, V_RES, 1), "res_stall0");
        step(7'd0, C(4, V_RES, 1), "res_stall1");
        step(RDY, C(5, V_RES, 1), "res_c5");
        step(RDY, C(6, V_RES, 1), "res_c6");
        step(RDY, C(7, V_RES, 1), "res_c7");
        step(RDY, D(3'b001), "res_ack");
        step(RDY, D(3'b000), "res_after");

        // NMI hijacks an IRQ sequence in cycle 3
        step(IRQ | IB | RDY, C(1, V_IRQ, 0), "hij_c1");
        step(IRQ | RDY, C(2, V_IRQ, 0), "hij_c2");
        step(IRQ | RDY, C(3, V_IRQ, 0), "hij_c3");
        for (int n = 4; n <= 7; n++)
            step(NMI | IRQ | RDY, C(n, V_NMI, 0), $sformatf("hij_c%0d", n));
        step(RDY, D(3'b100), "hij_ack");
        step(RDY, D(3'b000), "hij_after");

        // Write cycles ignore RDYout; vector read stalls
        for (int n = 1; n <= 4; n++)
            step((n == 1) ? (IRQ | IB | RDY) : (IRQ | RDY), C(n, V_IRQ, 0), $sformatf("wr_c%0d", n));
        step(IRQ, C(5, V_IRQ, 0), "wr_nostall");
        step(IRQ | RDY, C(6, V_IRQ, 0), "wr_c6");
        step(IRQ, C(6, V_IRQ, 0), "vec_stall");
        step(IRQ | RDY, C(7, V_IRQ, 0), "wr_c7");
        step(IRQ | RDY, D(3'b010), "wr_ack");
        step(RDY, D(3'b000), "wr_after");

        // Asynchronous reset in cycle 5, then restart at the next boundary
        for (int n = 1; n <= 5; n++)
            step((n == 1) ? (IRQ | IB | RDY) : (IRQ | RDY), C(n, V_IRQ, 0), $sformatf("ar_c%0d", n));
        @(negedge phi1);
        #1;
        rstAll = 1'b1;
        #1;
        compare(D(3'b000), "async_reset");
        step(RST | IRQ | RDY, D(3'b000), "ar_held");
        step(IRQ | RDY, D(3'b000), "ar_release");
        step(IRQ | IB | RDY, C(1, V_IRQ, 0), "ar_restart_c1");
        for (int n = 2; n <= 7; n++)
            step(IRQ | RDY, C(n, V_IRQ, 0), $sformatf("ar_restart_c%0d", n));
        step(RDY, D(3'b010), "ar_ack");
        step(RDY, D(3'b000), "ar_after");

        repeat (3) @(negedge phi1);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
